viterbi_acs_unit: RTL and testbench
===================================

VITERBI_ACS_UNIT -- requirements
Module: viterbi_acs_unit

Interface
REQ-001 Parameter K, default 3: constraint length, legal 3..7; NS = 2^(K-1) states.
REQ-002 Parameter G0, default 3'b111 (K bits): generator for code bit c0.
REQ-003 Parameter G1, default 3'b101 (K bits): generator for code bit c1.
REQ-004 Parameter PM_W, default 6: path-metric width; PM_MAX = 2^PM_W-1.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 refresh  in  1  synchronous clear to initial state, active-high.
REQ-008 in_valid  in  1  symbol pair valid.
REQ-009 in_ready  out  1  unit can accept a symbol this cycle.
REQ-010 in_pair  in  2  hard-decision received bits; [1] compares to c0, [0] compares to c1.
REQ-011 in_last  in  1  marks final symbol of a frame.
REQ-012 out_valid  out  1  registered ACS result available.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 dec  out  NS  survivor decision bit per next-state.
REQ-015 pm_flat  out  NS*PM_W  path metrics; state s occupies bits [s*PM_W +: PM_W].
REQ-016 best_state  out  K-1  index of the minimum path metric.
REQ-017 best_metric  out  PM_W  value of the minimum path metric.
REQ-018 warm  out  1  at least K-1 symbols processed since reset/refresh.
REQ-019 out_last  out  1  registered copy of in_last for this result.

Function
REQ-020 State s holds the last K-1 inputs; input u moves s to ns = {u, s[K-2:1]}.
REQ-021 Transition code bits: r = {u, s}; c0 = XOR-reduce(r & G0); c1 = XOR-reduce(r & G1).
REQ-022 Branch metric = Hamming distance of in_pair vs {c0,c1}, range 0..2.
REQ-023 Predecessors of ns: p0 = {ns[K-3:0],0}, p1 = {ns[K-3:0],1}; u = ns[K-2].
REQ-024 Candidate = PM[p] + BM, saturated at PM_MAX; a PM_MAX operand yields PM_MAX.
REQ-025 Select the smaller candidate; tie selects p0; dec[ns] = 0 for p0, 1 for p1.
REQ-026 Normalise: subtract the minimum selected value from every selected value below PM_MAX; PM_MAX entries stay PM_MAX; minimum is 0 after every step.
REQ-027 best_state = lowest index holding the minimum; best_metric = that minimum pre-normalisation.
REQ-028 Accept = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-029 Latency 1 cycle: on accept, dec, pm_flat, best_*, out_last, warm update and out_valid = 1 on the next edge.
REQ-030 out_valid clears on out_ready without a concurrent accept; outputs hold while out_valid && !out_ready.
REQ-031 Step counter saturates at K-1; warm = (count == K-1); no wrap.
REQ-032 Accepting a symbol with in_last = 1 reloads PM to the initial state after that result; the next symbol starts a new frame; warm and the counter clear.
REQ-033 refresh has priority over accept in the same cycle; the symbol is dropped, out_valid = 0, and PM returns to the initial state.

Reset
REQ-034 rst or refresh: PM[0] = 0, PM[s != 0] = PM_MAX, out_valid = 0, dec = 0, best_state = 0, best_metric = 0, warm = 0, out_last = 0, counter = 0; pm_flat shows the initial metrics.
REQ-035 rst asserted mid-stream aborts immediately; no partial result is presented after release.

Verification (defaults K=3, G0=111, G1=101, PM_W=6)
REQ-036 After reset, feed in_pair=11 -> pm = [2,63,0,63], dec = 0000, best_state=2, best_metric=0, warm=0.
REQ-037 Error-free stream 11,10,00,01 (inputs 1,0,1,1) -> best_state 2,1,2,3, best_metric 0 on each step; warm rises on the 2nd result.
REQ-038 Hold out_ready=0 with in_valid=1 -> in_ready=0 after the 1st result, outputs stable, no symbol lost; release -> consecutive results with no bubble.
REQ-039 refresh together with in_valid mid-stream -> out_valid=0 next cycle, pm = [0,63,63,63], symbol not consumed; in_last on step 3 -> following result is computed from the initial metrics.
REQ-040 PM_W=3 with a 10-symbol all-error stream -> no metric exceeds 7, minimum is always 0, and metrics never wrap to small values.
REQ-041 Assert rst asynchronously between edges during streaming -> outputs reach reset values before the next edge.

Source files
------------

// File: rtl/viterbi_acs_unit.sv
// Viterbi add-compare-select unit: one trellis step per accepted hard-decision symbol pair.
// Latency: 1 cycle from accept to the registered result (dec, metrics, best state).
// Backpressure: in_ready = !out_valid || out_ready; the result holds while out_ready is low.

module viterbi_acs_unit #(
  parameter int            K    = 3,
  parameter logic [K-1:0]  G0   = 3'b111,
  parameter logic [K-1:0]  G1   = 3'b101,
  parameter int            PM_W = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          refresh,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_pair,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(1<<(K-1))-1:0]         dec,
  output logic [(1<<(K-1))*PM_W-1:0]    pm_flat,
  output logic [K-2:0]                  best_state,
  output logic [PM_W-1:0]               best_metric,
  output logic                          warm,
  output logic                          out_last
);

  localparam int              NS      = 1 << (K - 1);
  localparam int              SW      = K - 1;
  localparam int              CW      = $clog2(K);
  localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
  localparam logic [CW-1:0]   CNT_MAX = CW'(K - 1);

  // Hamming distance between the received pair and the code bits of transition (s, u).
  function automatic logic [1:0] branch_metric(input logic [SW-1:0] s, input logic u,
                                               input logic [1:0] pair);
    logic [K-1:0] r;
    logic         c0;
    logic         c1;
    r  = {u, s};
    c0 = ^(r & G0);
    c1 = ^(r & G1);
    return {1'b0, pair[1] ^ c0} + {1'b0, pair[0] ^ c1};
  endfunction

  // Saturating add; an unreachable (PM_MAX) predecessor stays unreachable.
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    if (pm == PM_MAX || sum > {1'b0, PM_MAX}) return PM_MAX;
    return sum[PM_W-1:0];
  endfunction

  // Predecessor of next-state ns whose oldest bit is b.
  function automatic logic [SW-1:0] pred(input logic [SW-1:0] ns, input logic b);
    return {ns[SW-2:0], b};
  endfunction

  logic [PM_W-1:0] pm_q [NS];
  logic [PM_W-1:0] pm_d [NS];
  logic [PM_W-1:0] src_pm [NS];
  logic [PM_W-1:0] cand0 [NS];
  logic [PM_W-1:0] cand1 [NS];
  logic [PM_W-1:0] sel_pm [NS];
  logic [PM_W-1:0] norm_pm [NS];
  logic [NS-1:0]   dec_c;
  logic [PM_W-1:0] min_pm;
  logic [SW-1:0]   min_idx;

  logic            restart_q, restart_d;
  logic            out_valid_q, out_valid_d;
  logic [NS-1:0]   dec_q, dec_d;
  logic [SW-1:0]   best_state_q, best_state_d;
  logic [PM_W-1:0] best_metric_q, best_metric_d;
  logic            warm_q, warm_d;
  logic            out_last_q, out_last_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Trellis step: source metrics (initial after a frame end), add-compare-select, min search, normalise.
  always_comb begin
    dec_c   = '0;
    min_pm  = '0;
    min_idx = '0;
    for (int s = 0; s < NS; s++) begin
      src_pm[s] = restart_q ? ((s == 0) ? '0 : PM_MAX) : pm_q[s];
    end
    for (int n = 0; n < NS; n++) begin
      cand0[n]  = sat_add(src_pm[pred(SW'(n), 1'b0)],
                          branch_metric(pred(SW'(n), 1'b0), n[SW-1], in_pair));
      cand1[n]  = sat_add(src_pm[pred(SW'(n), 1'b1)],
                          branch_metric(pred(SW'(n), 1'b1), n[SW-1], in_pair));
      dec_c[n]  = cand1[n] < cand0[n];
      sel_pm[n] = dec_c[n] ? cand1[n] : cand0[n];
    end
    min_pm = sel_pm[0];
    for (int n = 1; n < NS; n++) begin
      if (sel_pm[n] < min_pm) begin
        min_pm  = sel_pm[n];
        min_idx = SW'(n);
      end
    end
    for (int n = 0; n < NS; n++) begin
      norm_pm[n] = (sel_pm[n] == PM_MAX) ? PM_MAX : sel_pm[n] - min_pm;
    end
  end

  // Next state: refresh beats accept; an accepted in_last makes the next symbol start from initial metrics.
  always_comb begin
    cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    pm_d          = pm_q;
    restart_d     = restart_q;
    out_valid_d   = out_valid_q;
    dec_d         = dec_q;
    best_state_d  = best_state_q;
    best_metric_d = best_metric_q;
    warm_d        = warm_q;
    out_last_d    = out_last_q;
    cnt_d         = cnt_q;
    if (refresh) begin
      for (int s = 0; s < NS; s++) pm_d[s] = (s == 0) ? '0 : PM_MAX;
      restart_d     = 1'b0;
      out_valid_d   = 1'b0;
      dec_d         = '0;
      best_state_d  = '0;
      best_metric_d = '0;
      warm_d        = 1'b0;
      out_last_d    = 1'b0;
      cnt_d         = '0;
    end else if (accept) begin
      pm_d          = norm_pm;
      restart_d     = in_last;
      out_valid_d   = 1'b1;
      dec_d         = dec_c;
      best_state_d  = min_idx;
      best_metric_d = min_pm;
      warm_d        = (cnt_inc == CNT_MAX);
      out_last_d    = in_last;
      cnt_d         = in_last ? '0 : cnt_inc;
    end else if (out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  // State registers with asynchronous reset to the initial trellis state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) pm_q[s] <= (s == 0) ? '0 : PM_MAX;
      restart_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      dec_q         <= '0;
      best_state_q  <= '0;
      best_metric_q <= '0;
      warm_q        <= 1'b0;
      out_last_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      pm_q          <= pm_d;
      restart_q     <= restart_d;
      out_valid_q   <= out_valid_d;
      dec_q         <= dec_d;
      best_state_q  <= best_state_d;
      best_metric_q <= best_metric_d;
      warm_q        <= warm_d;
      out_last_q    <= out_last_d;
      cnt_q         <= cnt_d;
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_flat
    assign pm_flat[g*PM_W +: PM_W] = pm_q[g];
  end

  assign out_valid   = out_valid_q;
  assign dec         = dec_q;
  assign best_state  = best_state_q;
  assign best_metric = best_metric_q;
  assign warm        = warm_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_viterbi_acs_unit.sv
// Directed bench for viterbi_acs_unit: default K=3 instance plus a PM_W=3 instance for saturation.
// Expected metrics are hand-computed trellis steps for G0=111, G1=101.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at the same point.

module tb_viterbi_acs_unit;

  logic        clk = 1'b0;
  logic        rst, refresh, in_valid, in_last, out_ready;
  logic [1:0]  in_pair;
  logic        in_ready, out_valid, warm, out_last;
  logic [3:0]  dec;
  logic [23:0] pm_flat;
  logic [1:0]  best_state;
  logic [5:0]  best_metric;
  logic        in_ready3, out_valid3, warm3, out_last3;
  logic [3:0]  dec3;
  logic [11:0] pm_flat3;
  logic [1:0]  best_state3;
  logic [2:0]  best_metric3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  viterbi_acs_unit dut (
    .clk(clk), .rst(rst), .refresh(refresh), .in_valid(in_valid), .in_ready(in_ready),
    .in_pair(in_pair), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .dec(dec), .pm_flat(pm_flat), .best_state(best_state), .best_metric(best_metric),
    .warm(warm), .out_last(out_last)
  );

  viterbi_acs_unit #(.PM_W(3)) dut3 (
    .clk(clk), .rst(rst), .refresh(refresh), .in_valid(in_valid), .in_ready(in_ready3),
    .in_pair(in_pair), .in_last(in_last), .out_valid(out_valid3), .out_ready(out_ready),
    .dec(dec3), .pm_flat(pm_flat3), .best_state(best_state3), .best_metric(best_metric3),
    .warm(warm3), .out_last(out_last3)
  );

  function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
    return {d[5:0], c[5:0], b[5:0], a[5:0]};
  endfunction

  function automatic logic [11:0] pk3(input int a, input int b, input int c, input int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] p, input logic last, input logic rdy);
    in_valid  = v;
    in_pair   = p;
    in_last   = last;
    out_ready = rdy;
  endtask

  task automatic do_refresh();
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask

  task automatic test_reset();
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (pm_flat !== pk(0, 63, 63, 63)) begin failures++; $display("FAIL reset_pm got=%h exp=%h", pm_flat, pk(0, 63, 63, 63)); end
    checks++;
    if ({dec, best_state, best_metric, warm, out_last} !== 14'd0) begin
      failures++; $display("FAIL reset_outs got dec=%b bs=%0d bm=%0d warm=%b last=%b exp all 0", dec, best_state, best_metric, warm, out_last);
    end
    checks++;
  endtask

  task automatic test_first_symbol();
    drive(1'b1, 2'b11, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    if (out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", out_valid); end
    checks++;
    if (pm_flat !== pk(2, 63, 0, 63)) begin failures++; $display("FAIL first_pm got=%h exp=%h", pm_flat, pk(2, 63, 0, 63)); end
    checks++;
    if (dec !== 4'b0000) begin failures++; $display("FAIL first_dec got=%b exp=0000", dec); end
    checks++;
    if (best_state !== 2'd2 || best_metric !== 6'd0) begin
      failures++; $display("FAIL first_best got=%0d/%0d exp=2/0", best_state, best_metric);
    end
    checks++;
    if (warm !== 1'b0) begin failures++; $display("FAIL first_warm got=%b exp=0", warm); end
    checks++;
    tick();
    if (out_valid !== 1'b0) begin failures++; $display("FAIL first_drain got=%b exp=0", out_valid); end
    checks++;
  endtask

  task automatic test_error_free();
    logic [1:0]  pairs [4];
    logic [23:0] exp_pm [4];
    logic [1:0]  exp_bs [4];
    logic [3:0]  exp_dec [4];
    logic        exp_warm [4];
    pairs   = '{2'b11, 2'b10, 2'b00, 2'b01};
    exp_pm  = '{pk(2, 63, 0, 63), pk(3, 0, 3, 2), pk(2, 3, 0, 3), pk(3, 2, 3, 0)};
    exp_bs  = '{2'd2, 2'd1, 2'd2, 2'd3};
    exp_dec = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};
    exp_warm = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_refresh();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pairs[i], 1'b0, 1'b1);
      tick();
      if (out_valid !== 1'b1 || pm_flat !== exp_pm[i]) begin
        failures++; $display("FAIL ef_pm step%0d got v=%b pm=%h exp v=1 pm=%h", i, out_valid, pm_flat, exp_pm[i]);
      end
      checks++;
      if (best_state !== exp_bs[i] || best_metric !== 6'd0) begin
        failures++; $display("FAIL ef_best step%0d got=%0d/%0d exp=%0d/0", i, best_state, best_metric, exp_bs[i]);
      end
      checks++;
      if (dec !== exp_dec[i] || warm !== exp_warm[i]) begin
        failures++; $display("FAIL ef_dec_warm step%0d got=%b/%b exp=%b/%b", i, dec, warm, exp_dec[i], exp_warm[i]);
      end
      checks++;
    end
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    do_refresh();
    drive(1'b1, 2'b11, 1'b0, 1'b0);
    tick();
    in_pair = 2'b10;
    for (int i = 0; i < 3; i++) begin
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", i, in_ready); end
      checks++;
      if (out_valid !== 1'b1 || pm_flat !== pk(2, 63, 0, 63) || best_state !== 2'd2) begin
        failures++; $display("FAIL bp_hold cyc%0d got v=%b pm=%h bs=%0d exp v=1 pm=%h bs=2", i, out_valid, pm_flat, best_state, pk(2, 63, 0, 63));
      end
      checks++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    if (out_valid !== 1'b1 || pm_flat !== pk(3, 0, 3, 2) || best_state !== 2'd1) begin
      failures++; $display("FAIL bp_release got v=%b pm=%h bs=%0d exp v=1 pm=%h bs=1", out_valid, pm_flat, best_state, pk(3, 0, 3, 2));
    end
    checks++;
    in_pair = 2'b00;
    tick();
    if (out_valid !== 1'b1 || pm_flat !== pk(2, 3, 0, 3) || dec !== 4'b1111) begin
      failures++; $display("FAIL bp_b2b_3 got v=%b pm=%h dec=%b exp v=1 pm=%h dec=1111", out_valid, pm_flat, dec, pk(2, 3, 0, 3));
    end
    checks++;
    in_pair = 2'b01;
    tick();
    if (out_valid !== 1'b1 || pm_flat !== pk(3, 2, 3, 0) || best_state !== 2'd3) begin
      failures++; $display("FAIL bp_b2b_4 got v=%b pm=%h bs=%0d exp v=1 pm=%h bs=3", out_valid, pm_flat, best_state, pk(3, 2, 3, 0));
    end
    checks++;
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_refresh_last();
    do_refresh();
    drive(1'b1, 2'b11, 1'b0, 1'b1);
    tick();
    in_pair = 2'b10;
    tick();
    in_pair = 2'b00;
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    if (out_valid !== 1'b0 || pm_flat !== pk(0, 63, 63, 63)) begin
      failures++; $display("FAIL refresh_state got v=%b pm=%h exp v=0 pm=%h", out_valid, pm_flat, pk(0, 63, 63, 63));
    end
    checks++;
    if (dec !== 4'b0000 || warm !== 1'b0 || best_state !== 2'd0) begin
      failures++; $display("FAIL refresh_outs got dec=%b warm=%b bs=%0d exp 0000/0/0", dec, warm, best_state);
    end
    checks++;
    in_pair = 2'b11;
    tick();
    if (pm_flat !== pk(2, 63, 0, 63)) begin failures++; $display("FAIL refresh_dropped got=%h exp=%h", pm_flat, pk(2, 63, 0, 63)); end
    checks++;
    in_pair = 2'b10;
    tick();
    drive(1'b1, 2'b00, 1'b1, 1'b1);
    tick();
    if (pm_flat !== pk(2, 3, 0, 3) || out_last !== 1'b1 || warm !== 1'b1) begin
      failures++; $display("FAIL last_result got pm=%h last=%b warm=%b exp pm=%h last=1 warm=1", pm_flat, out_last, warm, pk(2, 3, 0, 3));
    end
    checks++;
    drive(1'b1, 2'b11, 1'b0, 1'b1);
    tick();
    if (pm_flat !== pk(2, 63, 0, 63) || best_state !== 2'd2 || best_metric !== 6'd0) begin
      failures++; $display("FAIL new_frame got pm=%h bs=%0d bm=%0d exp pm=%h bs=2 bm=0", pm_flat, best_state, best_metric, pk(2, 63, 0, 63));
    end
    checks++;
    if (out_last !== 1'b0 || warm !== 1'b0) begin
      failures++; $display("FAIL new_frame_flags got last=%b warm=%b exp 0/0", out_last, warm);
    end
    checks++;
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_async_reset();
    do_refresh();
    drive(1'b1, 2'b11, 1'b0, 1'b1);
    tick();
    in_pair = 2'b10;
    tick();
    in_pair = 2'b00;
    #3;
    rst = 1'b1;
    #1;
    if (out_valid !== 1'b0 || pm_flat !== pk(0, 63, 63, 63)) begin
      failures++; $display("FAIL arst_immediate got v=%b pm=%h exp v=0 pm=%h", out_valid, pm_flat, pk(0, 63, 63, 63));
    end
    checks++;
    if ({dec, best_state, best_metric, warm} !== 13'd0) begin
      failures++; $display("FAIL arst_outs got dec=%b bs=%0d bm=%0d warm=%b exp all 0", dec, best_state, best_metric, warm);
    end
    checks++;
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    tick();
    if (out_valid !== 1'b0 || pm_flat !== pk(0, 63, 63, 63)) begin
      failures++; $display("FAIL arst_release got v=%b pm=%h exp v=0 pm=%h", out_valid, pm_flat, pk(0, 63, 63, 63));
    end
    checks++;
  endtask

  task automatic test_saturation();
    logic [11:0] exp_pm [10];
    logic [1:0]  exp_bs [10];
    logic [2:0]  exp_bm [10];
    logic [3:0]  exp_dec [10];
    logic [2:0]  mn;
    exp_pm  = '{pk3(2, 7, 0, 7), pk3(3, 0, 1, 0), pk3(0, 1, 2, 1), pk3(1, 2, 0, 2), pk3(1, 0, 0, 0),
                pk3(0, 1, 1, 1), pk3(1, 2, 0, 2), pk3(1, 0, 0, 0), pk3(0, 1, 1, 1), pk3(1, 2, 0, 2)};
    exp_bs  = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
    exp_bm  = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    exp_dec = '{4'b0000, 4'b0000, 4'b1111, 4'b1011, 4'b0001,
                4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    do_refresh();
    drive(1'b1, 2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid3 !== 1'b1 || pm_flat3 !== exp_pm[i]) begin
        failures++; $display("FAIL sat_pm step%0d got v=%b pm=%h exp v=1 pm=%h", i, out_valid3, pm_flat3, exp_pm[i]);
      end
      checks++;
      if (best_state3 !== exp_bs[i] || best_metric3 !== exp_bm[i] || dec3 !== exp_dec[i]) begin
        failures++; $display("FAIL sat_best step%0d got bs=%0d bm=%0d dec=%b exp bs=%0d bm=%0d dec=%b",
                             i, best_state3, best_metric3, dec3, exp_bs[i], exp_bm[i], exp_dec[i]);
      end
      checks++;
      mn = 3'd7;
      for (int s = 0; s < 4; s++) if (pm_flat3[s*3 +: 3] < mn) mn = pm_flat3[s*3 +: 3];
      if (mn !== 3'd0) begin failures++; $display("FAIL sat_min step%0d got=%0d exp=0", i, mn); end
      checks++;
    end
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    refresh = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    test_reset();
    test_first_symbol();
    test_error_free();
    test_back_to_back();
    test_refresh_last();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
